// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_pkg
// Purpose  : Shared types and constants for the four-digit seven-segment
//            scanner: scan FSM state encoding, blanked anode/segment values
//            and the active-low hex glyph table.
// Revision : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

    // Scan FSM states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        OFF = 2'd0,
        ON  = 2'd1,
        GAP = 2'd2
    } scan_state_t;

    // All anodes dark (active-low).
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Active-low glyphs, MSB..LSB = a,b,c,d,e,f,g. Index 0 is listed first.
    localparam logic [0:15][6:0] SEG_TABLE = {
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage : seg_scan_pkg
`default_nettype wire

// File: rtl/seg_scan_display_lut.sv
`default_nettype none
// ============================================================================
// Module   : hex2_7seg_lut
// Purpose  : Combinational hex nibble to active-low seven-segment glyph.
// Ports    : nibble [3:0] in  - hex value 0..F
//            seg_n  [0:6] out - active-low segments, seg_n[0]=a .. seg_n[6]=g
// Revision : 1.0 - initial release
// ============================================================================
module hex2_7seg_lut
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [0:6] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule : hex2_7seg_lut
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_display
// Purpose  : Four-digit time-multiplexed seven-segment scanner. Accepts a
//            16-bit hex word over valid/ready into a one-deep pending buffer
//            and commits it to the display register only at the end of a
//            full frame, so a frame is never torn. A guard gap with all
//            anodes dark separates consecutive digits.
// Ports    : CLK1       in   system clock
//            arst       in   synchronous active-high reset
//            en         in   scan enable, 0 blanks the display
//            din[15:0]  in   packed hex digits, din[3:0] is digit 0 (an[0])
//            din_dp[3:0]in   decimal point per digit, 1 = lit
//            din_valid  in   din/din_dp offered
//            din_ready  out  pending buffer empty
//            seg[0:N-1] out  active-low segments, seg[0]=a .. seg[6]=g
//            dp         out  active-low decimal point
//            an[3:0]    out  active-low anodes, at most one low
//            frame_done out  one-cycle pulse as digit 3's ON period ends
// Options  : SEG_SCAN_ZERO_BLANK_EN - blank leading zero digits (digit 0
//            is never blanked).
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_display
    import seg_scan_pkg::*;
#(
    parameter int N     = 7,
    parameter int DIV   = 50_000,
    parameter int GUARD = 64
) (
    input  logic         CLK1,
    input  logic         arst,
    input  logic         en,
    input  logic [15:0]  din,
    input  logic [3:0]   din_dp,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [0:N-1] seg,
    output logic         dp,
    output logic [3:0]   an,
    output logic         frame_done
);

    // One prescaler serves both the ON and the GAP phase.
    localparam int c_cnt_max = (DIV > GUARD) ? DIV : GUARD;
    localparam int c_pw      = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_pw-1:0] c_div_last   = c_pw'(DIV - 1);
    localparam logic [c_pw-1:0] c_guard_last = c_pw'(GUARD - 1);

    scan_state_t     r_state;
    logic [1:0]      r_idx;
    logic [c_pw-1:0] r_presc;

    logic [15:0]     r_pend;
    logic [3:0]      r_pend_dp;
    logic            r_pend_valid;
    logic [15:0]     r_disp;
    logic [3:0]      r_disp_dp;

    logic [3:0]      r_an;
    logic [0:N-1]    r_seg;
    logic            r_dp;
    logic            r_frame_done;

    logic            w_on;
    logic            w_commit;
    logic [3:0]      w_nibble;
    logic [0:6]      w_glyph;
    logic            w_blank;
    logic [3:0]      w_an_on;

    // en gates everything so the display goes dark on the edge that sees en=0.
    assign w_on     = en && (r_state == ON);
    assign w_commit = w_on && (r_presc == c_div_last) && (r_idx == 2'd3);
    assign w_nibble = r_disp[{r_idx, 2'b00} +: 4];
    assign w_an_on  = ANODE_OFF ^ (4'b0001 << r_idx);

    hex2_7seg_lut u_lut (
        .nibble (w_nibble),
        .seg_n  (w_glyph)
    );

    // A digit is a leading zero when it and every higher nibble are 0 and
    // its own decimal point is off.
    always_comb begin
        w_blank = 1'b0;
`ifdef SEG_SCAN_ZERO_BLANK_EN
        case (r_idx)
            2'd3:    w_blank = (r_disp[15:12] == 4'h0)  && !r_disp_dp[3];
            2'd2:    w_blank = (r_disp[15:8]  == 8'h00) && !r_disp_dp[2];
            2'd1:    w_blank = (r_disp[15:4]  == 12'h0) && !r_disp_dp[1];
            default: w_blank = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge CLK1) begin
        if (arst) begin
            r_state      <= OFF;
            r_idx        <= 2'd0;
            r_presc      <= '0;
            r_pend       <= 16'h0000;
            r_pend_dp    <= 4'b0000;
            r_pend_valid <= 1'b0;
            r_disp       <= 16'h0000;
            r_disp_dp    <= 4'b0000;
            r_an         <= ANODE_OFF;
            r_seg        <= '1;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            // Scan FSM
            if (!en) begin
                r_state <= OFF;
                r_idx   <= 2'd0;
                r_presc <= '0;
            end else begin
                case (r_state)
                    OFF: begin
                        r_state <= ON;
                        r_idx   <= 2'd0;
                        r_presc <= '0;
                    end
                    ON: begin
                        if (r_presc == c_div_last) begin
                            r_state <= GAP;
                            r_presc <= '0;
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    GAP: begin
                        if (r_presc == c_guard_last) begin
                            r_state <= ON;
                            r_presc <= '0;
                            r_idx   <= r_idx + 2'd1;
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= OFF;
                        r_idx   <= 2'd0;
                        r_presc <= '0;
                    end
                endcase
            end

            // Commit and accept are mutually exclusive: a commit needs the
            // buffer full, an accept needs it empty.
            if (w_commit && r_pend_valid) begin
                r_disp       <= r_pend;
                r_disp_dp    <= r_pend_dp;
                r_pend_valid <= 1'b0;
            end else if (din_valid && !r_pend_valid) begin
                r_pend       <= din;
                r_pend_dp    <= din_dp;
                r_pend_valid <= 1'b1;
            end

            // Registered outputs, one cycle behind the scan state.
            r_frame_done <= w_commit;
            r_an         <= w_on ? w_an_on : ANODE_OFF;
            r_seg        <= (w_on && !w_blank) ? w_glyph : '1;
            r_dp         <= w_on ? ~r_disp_dp[r_idx] : 1'b1;
        end
    end

    assign din_ready  = ~r_pend_valid;
    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule : seg_scan_display
`default_nettype wire

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Four-digit time-multiplexed seven-segment scanner, downstream of the one-second counter stage.
- Accepts a 16-bit packed hex word (4 nibbles) through a valid/ready handshake and buffers it.
- Latches the word into the display register only at frame boundaries, so no torn frames are shown.
- Drives active-low anodes and segments, with a guard gap between digits to suppress ghosting.

Parameters:
- N, 7: segment count; seg is [0:N-1], seg[0]=a ... seg[6]=g.
- DIV, 50_000: CLK1 cycles each digit is lit (1 kHz per digit at 50 MHz).
- GUARD, 64: CLK1 cycles all anodes are off between digits; must be ≥1.

Ports:
- CLK1  in  1  system clock.
- arst  in  1  reset, synchronous, active-high.
- en  in  1  scan enable; 0 blanks the display.
- din  in  16  packed hex digits; din[3:0] is digit 0 (rightmost, an[0]).
- din_dp  in  4  decimal point per digit, 1 = lit.
- din_valid  in  1  din/din_dp offered.
- din_ready  out  1  pending buffer empty.
- seg  out  [0:N-1]  active-low segments of the current digit.
- dp  out  1  active-low decimal point.
- an  out  4  active-low anodes; at most one bit is 0.
- frame_done  out  1  one-cycle pulse when digit 3's ON period ends.

Behaviour:
- One clock, CLK1. Reset is synchronous and active-high on arst. All state is updated on posedge CLK1.
- Reset values:
  - FSM=OFF, digit index=0, prescaler=0.
  - pending_valid=0, display register=16'h0000, dp register=4'b0000.
  - an=4'b1111, seg=7'b1111111, dp=1, frame_done=0, din_ready=1.
- FSM states:
  - OFF: an=4'b1111. Moves to ON with index=0 when en=1.
  - ON: drives an[index]=0 for DIV cycles. Prescaler counts 0..DIV-1, then the FSM moves to GAP.
  - GAP: an=4'b1111 for GUARD cycles, then index=index+1 (mod 4) and back to ON.
  - en=0 in any state: OFF on the next edge, with index and prescaler cleared.
- Handshake:
  - din_ready = ~pending_valid.
  - A transfer occurs when din_valid && din_ready; din and din_dp are captured into pending and pending_valid is set.
  - Offered data is held by the source until accepted.
- Frame commit:
  - On the ON→GAP transition of index 3, frame_done pulses that cycle.
  - If pending_valid is set, pending is copied into the display register and pending_valid clears.
  - din_ready rises the next cycle.
  - A transfer attempt in the same cycle as a commit is not accepted, because din_ready was 0.
- Output path:
  - seg and dp are registered: one cycle latency from index/display change, aligned with an (an is also registered).
  - Segments come from a hex lookup of the display nibble. 0..F map to standard glyphs; segment lit = 0.
  - In OFF or GAP, seg is forced to all 1s.
- Arithmetic: prescaler width is clog2(DIV); index is 2 bits and wraps 3→0.
- Reset mid-scan or with pending data: everything returns to reset values on the next edge; the pending word is discarded.

Optional Feature:
- Macro: SEG_SCAN_ZERO_BLANK_EN.
- Defined: leading zeros are blanked. A digit is suppressed (seg all 1s, an still cycles) when its nibble and every higher nibble are 0 and its dp is 0. Digit 0 is never blanked, so 16'h0000 shows "0".
- Undefined: all four digits are always shown.

Decomposition:
- Package seg_scan_pkg holds:
  - FSM state enum {OFF, ON, GAP};
  - the 16-entry active-low segment constant table;
  - ANODE_OFF=4'b1111.
- Sub-module: the existing hex2_7seg_lut, instantiated once on the selected nibble, with output inversion/blanking muxed after it.

Test Plan:
- Bench parameters: DIV=8, GUARD=2, en=1.
- Reset: arst=1 for 2 cycles → an=1111, seg=1111111, din_ready=1. Then the first ON starts with an=1110 one cycle after the FSM enters ON.
- Scan timing: 16'h1234 committed → repeating pattern an=1110 (seg=glyph 4) for 8 cycles, 1111 for 2, 1101 (glyph 3) for 8, and so on. frame_done pulses once every 40 cycles.
- Handshake/commit: offer 16'hABCD mid-frame → accepted in 1 cycle, din_ready=0 until frame_done, display changes only from the next digit-0 ON. A second word 16'h5555 offered while not ready stays waiting and commits at the following frame.
- en toggle: en=0 during digit 2 ON → an=1111 next cycle. en=1 → resumes at digit 0 with prescaler reset.
- Mid-operation reset: arst during GAP with pending valid → pending dropped, display=0000, state=OFF.
- Macro on: din=16'h0050, dp=0000 → digits 3 and 2 blanked, digit 1 shows "5", digit 0 shows "0". With din_dp=4'b1000, digit 3 shows "0." instead.
